xillybus_upstream_arbiter: RTL

//  Shares one Xillybus FPGA->host FIFO write port among N_REQ requester streams on bus_clk.

---
 rtl/xillybus_arb_pkg.sv | 18 +
 rtl/xillybus_rr_pick.sv | 29 ++
 rtl/xillybus_upstream_arbiter.sv | 156 +++++++++++++++
 3 files changed

// File: rtl/xillybus_arb_pkg.sv
// Shared types and constants for the Xillybus upstream arbiter.
package xillybus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HDR   = 2'd1,
    XFER  = 2'd2,
    FLUSH = 2'd3
  } state_t;

  localparam logic [7:0] HDR_MAGIC = 8'hA5;

  // Width of a requester index; never narrower than one bit.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/xillybus_rr_pick.sv
// Round-robin picker: first set bit of valid strictly after ptr, wrapping.
module xillybus_rr_pick
  import xillybus_arb_pkg::*;
#(
  parameter int N = 4,
  parameter int W = grant_w(N)
) (
  input  logic [N-1:0] valid,
  input  logic [W-1:0] ptr,
  output logic [W-1:0] idx,
  output logic         any_valid
);

  // Scan from farthest to nearest so the nearest valid index is written last.
  always_comb begin
    int c;
    idx       = '0;
    any_valid = 1'b0;
    c         = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (valid[c]) begin
        idx       = c[W-1:0];
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/xillybus_upstream_arbiter.sv
// Packet-granular round-robin arbiter sharing one Xillybus FPGA->host FIFO
// write port, with flush-on-close and status LEDs.
// Optional macro XILLYBUS_ARB_HEADER_EN: prefix each packet with a header word
// {A5, grant_id, seq}.
//
// state | meaning
// IDLE  | no grant; arbitrate among valid requesters when host_open
// HDR   | write the packet header word (header build only)
// XFER  | pass beats of granted requester straight to the FIFO
// FLUSH | host closed mid-packet; swallow beats until last
module xillybus_upstream_arbiter
  import xillybus_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int DATA_W      = 32,
  parameter int LED_STRETCH = 2**22
) (
  input  logic                         bus_clk,
  input  logic                         rst_b,
  input  logic [N_REQ-1:0]             req_valid,
  input  logic [N_REQ*DATA_W-1:0]      req_data,
  input  logic [N_REQ-1:0]             req_last,
  output logic [N_REQ-1:0]             req_ready,
  input  logic                         host_open,
  input  logic                         fifo_full,
  output logic                         fifo_wr_en,
  output logic [DATA_W-1:0]            fifo_wr_data,
  output logic [grant_w(N_REQ)-1:0]    grant_id,
  output logic [3:0]                   led
);

  localparam int GW = grant_w(N_REQ);
  localparam int CW = $clog2(LED_STRETCH + 1);
  localparam logic [CW-1:0] LED_RELOAD = CW'(LED_STRETCH);

  state_t              state;
  logic [GW-1:0]       rr_ptr;
  logic [GW-1:0]       pick_idx;
  logic                pick_any;
  logic                drop;
  logic [CW-1:0]       stretch_cnt;
  logic                g_valid;
  logic                g_last;
  logic [DATA_W-1:0]   g_data;

`ifdef XILLYBUS_ARB_HEADER_EN
  logic [15:0] seq;
  logic [31:0] hdr_word;

  assign hdr_word = {HDR_MAGIC, 8'(grant_id), seq};

  if (DATA_W < 32) begin : g_bad_width
    $error("xillybus_upstream_arbiter: DATA_W must be >= 32 with header enabled");
  end
`endif

  xillybus_rr_pick #(.N(N_REQ), .W(GW)) u_pick (
    .valid     (req_valid),
    .ptr       (rr_ptr),
    .idx       (pick_idx),
    .any_valid (pick_any)
  );

  assign g_valid = req_valid[grant_id];
  assign g_last  = req_last[grant_id];
  assign g_data  = req_data[int'(grant_id)*DATA_W +: DATA_W];

  // Handshake and FIFO write path; combinational so beats pass with zero latency.
  always_comb begin
    req_ready    = '0;
    fifo_wr_en   = 1'b0;
    fifo_wr_data = '0;
    case (state)
      XFER: begin
        req_ready[grant_id] = host_open & ~fifo_full;
        fifo_wr_en          = g_valid & host_open & ~fifo_full;
        fifo_wr_data        = g_data;
      end
      FLUSH: begin
        req_ready[grant_id] = 1'b1;
      end
`ifdef XILLYBUS_ARB_HEADER_EN
      HDR: begin
        fifo_wr_en   = host_open & ~fifo_full;
        fifo_wr_data = DATA_W'(hdr_word);
      end
`endif
      default: ;
    endcase
  end

  // Arbitration FSM: grant held from first beat until the accepted last beat.
  always_ff @(posedge bus_clk or negedge rst_b) begin
    if (!rst_b) begin
      state    <= IDLE;
      grant_id <= '0;
      rr_ptr   <= GW'(N_REQ - 1);
      drop     <= 1'b0;
`ifdef XILLYBUS_ARB_HEADER_EN
      seq      <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (host_open && pick_any) begin
            grant_id <= pick_idx;
            rr_ptr   <= pick_idx;
`ifdef XILLYBUS_ARB_HEADER_EN
            state    <= HDR;
`else
            state    <= XFER;
`endif
          end
        end
`ifdef XILLYBUS_ARB_HEADER_EN
        HDR: begin
          if (!host_open) begin
            state <= FLUSH;
            drop  <= 1'b1;
          end else if (!fifo_full) begin
            seq   <= seq + 16'd1;
            state <= XFER;
          end
        end
`endif
        XFER: begin
          if (!host_open) begin
            state <= FLUSH;
            drop  <= 1'b1;
          end else if (fifo_wr_en && g_last) begin
            state <= IDLE;
          end
        end
        FLUSH: begin
          if (g_valid && g_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Activity stretch: reload on every write, count down to zero.
  always_ff @(posedge bus_clk or negedge rst_b) begin
    if (!rst_b) begin
      stretch_cnt <= '0;
    end else if (fifo_wr_en) begin
      stretch_cnt <= LED_RELOAD;
    end else if (stretch_cnt != '0) begin
      stretch_cnt <= stretch_cnt - CW'(1);
    end
  end

  // host_open LED is gated by reset so all LEDs read dark while held in reset.
  assign led = {drop, (stretch_cnt != '0), (state != IDLE), (host_open & rst_b)};

endmodule
